tnn_seq_sum_cmp: RTL and testbench
==================================

// Module: tnn_seq_sum_cmp
// PURPOSE
//  Sequential, parametrised successor of the fixed 5-operand sum comparator neuron (2 positive vs 3 negative 3-bit terms).
//  Streams up to MAX_TERMS unsigned terms, each tagged positive or negative, into two accumulators.
//  On the last term emits one threshold bit (pos > neg, or pos >= neg) plus the signed margin.
//  Sits between the TNN input feature stream and the next layer's input register; one neuron evaluation per packet.
// PARAMETERS
//  IN_W      3   width of each unsigned input term
//  MAX_TERMS 8   maximum terms per packet (pos+neg combined), >= 2
//  ACC_W     6   accumulator width per group; default holds MAX_TERMS*(2^IN_W-1) without overflow
//  STRICT    1   1: out_bit = pos > neg; 0: out_bit = pos >= neg
// PORTS
//  clk        in   1        single clock, rising edge
//  rst        in   1        asynchronous, active-high reset
//  in_valid   in   1        term beat valid
//  in_ready   out  1        block accepts a term this cycle
//  in_data    in   IN_W     unsigned term value
//  in_neg     in   1        0: add to pos accumulator; 1: add to neg accumulator
//  in_last    in   1        final term of packet
//  out_valid  out  1        result valid; held until out_ready
//  out_ready  in   1        consumer accepts result
//  out_bit    out  1        threshold decision
//  out_diff   out  ACC_W+1  signed two's-complement pos_acc - neg_acc
//  out_err    out  1        packet truncated at MAX_TERMS (no in_last seen)
// BEHAVIOUR
//  - Reset (async, any time incl. mid-packet): state=ACC, pos_acc=neg_acc=0, term count=0, in_ready=1 once rst deasserts, out_valid=0, out_bit=0, out_diff=0, out_err=0. Partial packet discarded.
//  - FSM: ACC (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
//  - Accept = in_valid & in_ready. On accept in ACC: in_data zero-extended to ACC_W and added to the group selected by in_neg; count += 1.
//  - ACC->HOLD on accept with in_last=1, or on accept with count==MAX_TERMS-1 and in_last=0 (implicit last, out_err=1).
//  - Result registered: out_bit/out_diff/out_err reflect all accepted terms incl. the closing one, valid the cycle after the closing accept (latency 1).
//  - HOLD: out_* stable while out_ready=0. On out_ready=1: accumulators, count and out_err clear; next cycle state=ACC, out_valid=0, in_ready=1. No same-cycle result/term overlap.
//  - in_valid during HOLD ignored (no accept). in_data/in_neg/in_last are don't-care when in_valid=0.
//  - Single-term packet (in_last on first beat) legal; empty group sums to 0.
//  - out_bit: STRICT=1 -> (pos_acc > neg_acc); STRICT=0 -> (pos_acc >= neg_acc); unsigned compare on ACC_W bits.
//  - out_diff computed in ACC_W+1 bits, never overflows.
// CONFIGURATION
//  TNN_SEQ_CMP_SAT_EN defined: each accumulator saturates at 2^ACC_W-1 (lets ACC_W be undersized for area); compare and out_diff use saturated values.
//  TNN_SEQ_CMP_SAT_EN undefined: accumulators wrap modulo 2^ACC_W; correctness requires default-sized ACC_W.
// TESTING
//  1) Defaults: pos 3,2; neg 1,1,2(last) -> out_valid next cycle, out_bit=1, out_diff=+1, out_err=0.
//  2) STRICT=1 tie: pos 4; neg 4(last) -> out_bit=0, out_diff=0; same with STRICT=0 -> out_bit=1.
//  3) 8 terms of 7, no in_last, alternate pos/neg -> HOLD after 8th accept, out_err=1, out_diff=0, further in_valid ignored.
//  4) Hold out_ready=0 for 5 cycles -> outputs stable, in_ready=0; out_ready=1 -> in_ready=1 next cycle, new packet pos 1(last) -> out_bit=1, diff=+1.
//  5) rst pulse after 2 of 4 terms -> all outputs 0; restart packet pos 2; neg 5(last) -> out_bit=0, out_diff=-3 (only new terms counted).
//  6) SAT_EN, IN_W=3, ACC_W=4: pos 7,7,7; neg 1(last) -> pos_acc=15, out_diff=+14, out_bit=1; SAT_EN off -> pos_acc=5, out_diff=+4.

Source files
------------

// File: rtl/tnn_seq_sum_cmp.sv
// Sequential sum-comparator neuron: streams tagged terms into pos/neg accumulators, emits threshold bit + signed margin.
// Optional macro TNN_SEQ_CMP_SAT_EN: accumulators saturate at 2^ACC_W-1 instead of wrapping.
module tnn_seq_sum_cmp #(
  parameter int IN_W      = 3,
  parameter int MAX_TERMS = 8,
  parameter int ACC_W     = 6,
  parameter int STRICT    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_neg,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_bit,
  output logic [ACC_W:0]   out_diff,
  output logic             out_err
);

  localparam int CNT_W = (MAX_TERMS > 2) ? $clog2(MAX_TERMS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_TERMS - 1);

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   pos_acc_q, pos_acc_d;
  logic [ACC_W-1:0]   neg_acc_q, neg_acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               out_bit_q, out_bit_d;
  logic [ACC_W:0]     out_diff_q, out_diff_d;
  logic               out_err_q, out_err_d;

  logic               accept;
  logic               close;
  logic [ACC_W-1:0]   term;
  logic [ACC_W-1:0]   pos_sum;
  logic [ACC_W-1:0]   neg_sum;

  // One extra bit catches the carry; it either clamps or is dropped.
  function automatic logic [ACC_W-1:0] acc_add(input logic [ACC_W-1:0] a,
                                               input logic [ACC_W-1:0] b);
    logic [ACC_W:0] s;
    s = {1'b0, a} + {1'b0, b};
`ifdef TNN_SEQ_CMP_SAT_EN
    return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
`else
    return s[ACC_W-1:0];
`endif
  endfunction

  assign in_ready  = (state_q == ST_ACC);
  assign out_valid = (state_q == ST_HOLD);
  assign accept    = in_valid && in_ready;
  assign close     = accept && (in_last || (cnt_q == LAST_CNT));
  assign term      = ACC_W'(in_data);
  assign pos_sum   = in_neg ? pos_acc_q : acc_add(pos_acc_q, term);
  assign neg_sum   = in_neg ? acc_add(neg_acc_q, term) : neg_acc_q;

  always_comb begin
    state_d    = state_q;
    pos_acc_d  = pos_acc_q;
    neg_acc_d  = neg_acc_q;
    cnt_d      = cnt_q;
    out_bit_d  = out_bit_q;
    out_diff_d = out_diff_q;
    out_err_d  = out_err_q;
    case (state_q)
      ST_ACC: begin
        if (accept) begin
          pos_acc_d = pos_sum;
          neg_acc_d = neg_sum;
          cnt_d     = cnt_q + 1'b1;
        end
        if (close) begin
          // Result is taken from the post-add sums so the closing term counts.
          state_d    = ST_HOLD;
          out_bit_d  = (STRICT != 0) ? (pos_sum > neg_sum) : (pos_sum >= neg_sum);
          out_diff_d = {1'b0, pos_sum} - {1'b0, neg_sum};
          out_err_d  = !in_last;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          state_d    = ST_ACC;
          pos_acc_d  = '0;
          neg_acc_d  = '0;
          cnt_d      = '0;
          out_bit_d  = 1'b0;
          out_diff_d = '0;
          out_err_d  = 1'b0;
        end
      end
      default: state_d = ST_ACC;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_ACC;
      pos_acc_q  <= '0;
      neg_acc_q  <= '0;
      cnt_q      <= '0;
      out_bit_q  <= 1'b0;
      out_diff_q <= '0;
      out_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pos_acc_q  <= pos_acc_d;
      neg_acc_q  <= neg_acc_d;
      cnt_q      <= cnt_d;
      out_bit_q  <= out_bit_d;
      out_diff_q <= out_diff_d;
      out_err_q  <= out_err_d;
    end
  end

  assign out_bit  = out_bit_q;
  assign out_diff = out_diff_q;
  assign out_err  = out_err_q;

endmodule

// File: tb/tb_tnn_seq_sum_cmp.sv
// Bench for tnn_seq_sum_cmp: directed packets plus random packets against a plain-arithmetic sum model.
// Three instances share stimulus: default, STRICT=0, and an undersized ACC_W=4 build.
module tb_tnn_seq_sum_cmp;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [2:0] in_data;
  logic       in_neg;
  logic       in_last;
  logic       out_ready;

  logic       in_ready_a, out_valid_a, out_bit_a, out_err_a;
  logic [6:0] out_diff_a;
  logic       in_ready_b, out_valid_b, out_bit_b, out_err_b;
  logic [6:0] out_diff_b;
  logic       in_ready_c, out_valid_c, out_bit_c, out_err_c;
  logic [4:0] out_diff_c;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: plain integer sums of the accepted terms of the current packet.
  int pos_sum = 0;
  int neg_sum = 0;

  always #5 clk = ~clk;

  tnn_seq_sum_cmp #(.IN_W(3), .MAX_TERMS(8), .ACC_W(6), .STRICT(1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_data(in_data), .in_neg(in_neg), .in_last(in_last),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_bit(out_bit_a),
    .out_diff(out_diff_a), .out_err(out_err_a)
  );

  tnn_seq_sum_cmp #(.IN_W(3), .MAX_TERMS(8), .ACC_W(6), .STRICT(0)) u_dut_ge (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_data(in_data), .in_neg(in_neg), .in_last(in_last),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_bit(out_bit_b),
    .out_diff(out_diff_b), .out_err(out_err_b)
  );

  tnn_seq_sum_cmp #(.IN_W(3), .MAX_TERMS(8), .ACC_W(4), .STRICT(1)) u_dut_small (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_c),
    .in_data(in_data), .in_neg(in_neg), .in_last(in_last),
    .out_valid(out_valid_c), .out_ready(out_ready), .out_bit(out_bit_c),
    .out_diff(out_diff_c), .out_err(out_err_c)
  );

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Value a 4-bit accumulator would hold for a true sum s.
  function automatic int small_acc(input int s);
`ifdef TNN_SEQ_CMP_SAT_EN
    return (s > 15) ? 15 : s;
`else
    return s % 16;
`endif
  endfunction

  task automatic check_result(input string tag, input bit exp_err);
    int ps;
    int ns;
    ps = small_acc(pos_sum);
    ns = small_acc(neg_sum);
    check_val({tag, ".out_valid"}, int'(out_valid_a), 1);
    check_val({tag, ".in_ready"},  int'(in_ready_a), 0);
    check_val({tag, ".out_bit"},   int'(out_bit_a), int'(pos_sum > neg_sum));
    check_val({tag, ".out_bit_ge"}, int'(out_bit_b), int'(pos_sum >= neg_sum));
    check_val({tag, ".out_diff"},  int'($signed(out_diff_a)), pos_sum - neg_sum);
    check_val({tag, ".out_err"},   int'(out_err_a), int'(exp_err));
    check_val({tag, ".small_diff"}, int'($signed(out_diff_c)), ps - ns);
    check_val({tag, ".small_bit"}, int'(out_bit_c), int'(ps > ns));
  endtask

  task automatic send_term(input int v, input bit neg, input bit last);
    int guard;
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 3'($urandom);
      in_neg   = 1'($urandom);
      in_last  = 1'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 3'(v);
    in_neg   = neg;
    in_last  = last;
    guard = 0;
    while (!in_ready_a && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      check_val("in_ready_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    check_val("busy.out_valid", int'(out_valid_a), 0);
    @(posedge clk);
    if (neg) neg_sum += v;
    else     pos_sum += v;
    #1;
    in_valid = 1'b0;
  endtask

  // Waits one cycle for the registered result, holds it (with stray in_valid), then hands it off.
  task automatic finish_packet(input string tag, input bit exp_err, input int hold_cycles);
    @(negedge clk);
    check_result(tag, exp_err);
    for (int i = 0; i < hold_cycles; i++) begin
      in_valid = 1'($urandom);
      in_data  = 3'($urandom);
      in_neg   = 1'($urandom);
      in_last  = 1'($urandom);
      @(negedge clk);
      check_result({tag, ".hold"}, exp_err);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    pos_sum = 0;
    neg_sum = 0;
    @(negedge clk);
    check_val({tag, ".released_valid"}, int'(out_valid_a), 0);
    check_val({tag, ".released_ready"}, int'(in_ready_a), 1);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_val("rst.out_valid", int'(out_valid_a), 0);
    check_val("rst.out_bit",   int'(out_bit_a), 0);
    check_val("rst.out_diff",  int'(out_diff_a), 0);
    check_val("rst.out_err",   int'(out_err_a), 0);
    @(negedge clk);
    rst = 1'b0;
    pos_sum = 0;
    neg_sum = 0;
    @(negedge clk);
    check_val("rst.in_ready", int'(in_ready_a), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit trunc;
    int len;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_neg    = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    #1;
    check_val("init.out_valid", int'(out_valid_a), 0);
    check_val("init.out_diff",  int'(out_diff_a), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_val("init.in_ready", int'(in_ready_a), 1);

    // Basic packet: +5 vs +4.
    send_term(3, 0, 0); send_term(2, 0, 0);
    send_term(1, 1, 0); send_term(1, 1, 0); send_term(2, 1, 1);
    $display("txn basic pos=%0d neg=%0d", pos_sum, neg_sum);
    finish_packet("basic", 0, 2);

    // Tie: strict says 0, non-strict says 1.
    send_term(4, 0, 0); send_term(4, 1, 1);
    $display("txn tie pos=%0d neg=%0d", pos_sum, neg_sum);
    finish_packet("tie", 0, 1);

    // Truncation at MAX_TERMS with stray beats during hold.
    for (int i = 0; i < 8; i++) send_term(7, 1'(i % 2), 0);
    $display("txn trunc pos=%0d neg=%0d", pos_sum, neg_sum);
    finish_packet("trunc", 1, 5);

    // Single-term packet.
    send_term(1, 0, 1);
    $display("txn single pos=%0d neg=%0d", pos_sum, neg_sum);
    finish_packet("single", 0, 0);

    // Mid-packet reset discards partial sums.
    send_term(2, 0, 0); send_term(3, 1, 0);
    pulse_reset();
    send_term(2, 0, 0); send_term(5, 1, 1);
    $display("txn after_rst pos=%0d neg=%0d", pos_sum, neg_sum);
    finish_packet("after_rst", 0, 1);

    // Overflows only the 4-bit instance.
    send_term(7, 0, 0); send_term(7, 0, 0); send_term(7, 0, 0); send_term(1, 1, 1);
    $display("txn sat pos=%0d neg=%0d", pos_sum, neg_sum);
    finish_packet("sat", 0, 1);

    for (int p = 0; p < 60; p++) begin
      trunc = ($urandom_range(0, 4) == 0);
      len   = trunc ? 8 : $urandom_range(1, 8);
      for (int i = 0; i < len; i++)
        send_term($urandom_range(0, 7), 1'($urandom_range(0, 1)), !trunc && (i == len - 1));
      $display("txn rand%0d len=%0d trunc=%0d pos=%0d neg=%0d", p, len, trunc, pos_sum, neg_sum);
      finish_packet("rand", trunc, $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
